texture_row_fetcher: RTL and testbench

TEXTURE_ROW_FETCHER -- requirements
Module: texture_row_fetcher

---
 rtl/texture_row_fetcher.sv | 154 +++++++++++++++
 tb/tb_texture_row_fetcher.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_row_fetcher.sv
// ---------------------------------------------------------------------------
// texture_row_fetcher
//
// Fetches one 8-texel row of an 8x8 texture tile from a synchronous texture
// memory (one-cycle read latency) and presents it as a single packed word.
// An optional horizontal mirror reorders the texels as they are stored.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   resetn     : asynchronous active-low reset
//   req_valid  : row-fetch request valid
//   req_ready  : high only while idle; request accepted on valid && ready
//   req_tile   : tile index (TILE_BITS)
//   req_row    : texel row inside the tile (3 bits)
//   req_flip   : mirror the row horizontally
//   flush      : synchronous abort, returns to idle on the next edge
//   mem_ren    : texture memory read enable
//   mem_raddr  : texture memory address {tile, row, col}
//   mem_rdata  : texture memory data, valid one clock after mem_ren
//   row_valid  : assembled row available (held until accepted)
//   row_ready  : consumer accepts the row on row_valid && row_ready
//   row_data   : 8 texels, pixel p in bits [BPP*p +: BPP], p=0 leftmost
//   busy       : high whenever not idle
// ---------------------------------------------------------------------------
module texture_row_fetcher #(
    parameter int TILE_BITS = 6,
    parameter int BPP       = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TILE_BITS-1:0]   req_tile,
    input  logic [2:0]             req_row,
    input  logic                   req_flip,
    input  logic                   flush,
    output logic                   mem_ren,
    output logic [TILE_BITS+5:0]   mem_raddr,
    input  logic [BPP-1:0]         mem_rdata,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [8*BPP-1:0]       row_data,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic [2:0]             w_pix;

    logic [TILE_BITS-1:0]   r_tile;
    logic [2:0]             r_row;
    logic                   r_flip;
    logic [2:0]             r_col;
    logic                   r_ren_d;    // a read was issued last cycle
    logic [2:0]             r_pix_d;    // pixel slot of that read
    logic [8*BPP-1:0]       r_row_data;

    // Mirroring maps column c to pixel 7-c, which is c with all bits inverted.
    assign w_pix     = r_col ^ {3{r_flip}};
    assign mem_raddr = {r_tile, r_row, r_col};
    assign row_data  = r_row_data;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 1'b0;
        mem_ren     = 1'b0;
        row_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_ren = 1'b1;
                if (r_col == 3'd7) begin
                    w_state_nxt = LAST;
                end
            end
            LAST: begin
                // Only waiting for the column-7 data to land.
                w_state_nxt = HOLD;
            end
            HOLD: begin
                row_valid = 1'b1;
                if (row_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Flush overrides everything, including a request arriving in IDLE.
        if (flush) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tile     <= '0;
            r_row      <= '0;
            r_flip     <= 1'b0;
            r_col      <= '0;
            r_ren_d    <= 1'b0;
            r_pix_d    <= '0;
            r_row_data <= '0;
        end else begin
            if (w_accept) begin
                r_tile <= req_tile;
                r_row  <= req_row;
                r_flip <= req_flip;
                r_col  <= '0;
            end else if (mem_ren && (r_col != 3'd7)) begin
                // Saturate at 7 so the counter never wraps into a ninth read.
                r_col <= r_col + 3'd1;
            end

            r_ren_d <= mem_ren;
            r_pix_d <= w_pix;

            // Data returned this cycle belongs to the pixel addressed last cycle.
            for (int p = 0; p < 8; p++) begin
                if (r_ren_d && (r_pix_d == 3'(p))) begin
                    r_row_data[BPP*p +: BPP] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_texture_row_fetcher.sv
module tb_texture_row_fetcher;

    localparam int TB_TILE_BITS = 6;
    localparam int TB_BPP       = 3;
    localparam int AW           = TB_TILE_BITS + 6;
    localparam int RW           = 8 * TB_BPP;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     req_valid;
    logic                     req_ready;
    logic [TB_TILE_BITS-1:0]  req_tile;
    logic [2:0]               req_row;
    logic                     req_flip;
    logic                     flush;
    logic                     mem_ren;
    logic [AW-1:0]            mem_raddr;
    logic [TB_BPP-1:0]        mem_rdata;
    logic                     row_valid;
    logic                     row_ready;
    logic [RW-1:0]            row_data;
    logic                     busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [TB_BPP-1:0] mem [0:(1<<AW)-1];

    int            addr_q[$];
    logic [RW-1:0] row_q[$];

    texture_row_fetcher #(
        .TILE_BITS(TB_TILE_BITS),
        .BPP      (TB_BPP)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tile (req_tile),
        .req_row  (req_row),
        .req_flip (req_flip),
        .flush    (flush),
        .mem_ren  (mem_ren),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_data (row_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous texture memory, one clock read latency.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference row: pixel p shows column (flip ? 7-p : p) of the tile row.
    function automatic logic [RW-1:0] exp_row(input int t, input int r, input bit f);
        logic [RW-1:0] v;
        v = '0;
        for (int p = 0; p < 8; p++) begin
            v[TB_BPP*p +: TB_BPP] = mem[t*64 + r*8 + (f ? 7 - p : p)];
        end
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit            flush_d  = 1'b0;
        bit            prev_ren = 1'b0;
        bit            prev_rv  = 1'b0;
        bit            aborted  = 1'b1;
        int            ren_run  = 0;
        int            acc_cyc  = 0;
        logic [RW-1:0] prev_rd  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                addr_q.delete();
                row_q.delete();
                aborted  = 1'b1;
                flush_d  = 1'b0;
                prev_ren = 1'b0;
                prev_rv  = 1'b0;
                ren_run  = 0;
            end else begin
                if (flush_d) begin
                    check("flush_ren", 64'(mem_ren), 64'd0);
                    check("flush_rv", 64'(row_valid), 64'd0);
                    check("flush_busy", 64'(busy), 64'd0);
                end
                if (mem_ren) begin
                    if (addr_q.size() == 0) fail("mem_ren_extra", "read issued with no outstanding address");
                    else check("mem_raddr", 64'(mem_raddr), 64'(addr_q.pop_front()));
                    ren_run++;
                end else begin
                    if (prev_ren && !aborted) check("ren_burst", 64'(ren_run), 64'd8);
                    ren_run = 0;
                end
                if (row_valid) begin
                    check("hold_req_ready", 64'(req_ready), 64'd0);
                    check("hold_mem_ren", 64'(mem_ren), 64'd0);
                    if (!prev_rv) begin
                        check("row_latency", 64'(cyc - acc_cyc), 64'd9);
                        check("reads_done", 64'(addr_q.size()), 64'd0);
                    end else begin
                        check("row_stable", 64'(row_data), 64'(prev_rd));
                    end
                    if (row_q.size() == 0) fail("row_unexpected", "row_valid high with no outstanding request");
                    else if (row_ready && !flush) check("row_data", 64'(row_data), 64'(row_q.pop_front()));
                end
                if (flush) begin
                    addr_q.delete();
                    row_q.delete();
                    aborted = 1'b1;
                end else if (req_valid && req_ready) begin
                    for (int c = 0; c < 8; c++) addr_q.push_back(int'(req_tile) * 64 + int'(req_row) * 8 + c);
                    row_q.push_back(exp_row(int'(req_tile), int'(req_row), req_flip));
                    acc_cyc = cyc + 1;
                    aborted = 1'b0;
                end
                flush_d  = flush;
                prev_ren = mem_ren;
                prev_rv  = row_valid;
                prev_rd  = row_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int t, input int r, input bit f, input bit keep, output int acc_at);
        bit done;
        done      = 1'b0;
        acc_at    = -1;
        req_tile  = TB_TILE_BITS'(t);
        req_row   = 3'(r);
        req_flip  = f;
        req_valid = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (req_ready && !flush) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (done) begin
            acc_at = cyc;
            if (!keep) req_valid = 1'b0;
        end else begin
            fail("send_timeout", "request not accepted within 60 cycles");
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        if (!done) fail("idle_timeout", "req_ready not seen within 80 cycles");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_row(output int seen_at);
        bit done;
        done    = 1'b0;
        seen_at = -1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (row_valid) begin
                done    = 1'b1;
                seen_at = cyc;
            end
        end
        if (!done) fail("row_timeout", "row_valid not seen within 40 cycles");
    endtask

    initial begin : driver
        int t;
        int s;
        int prev_t;
        bit acc;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_tile  = '0;
        req_row   = '0;
        req_flip  = 1'b0;
        flush     = 1'b0;
        row_ready = 1'b0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 3'(a & 7);

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_ren", 64'(mem_ren), 64'd0);
        check("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        check("rst_row_valid", 64'(row_valid), 64'd0);
        check("rst_row_data", 64'(row_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Tile 5 row 2, texel = column: pixel p holds p -> 0xFAC688.
        send(5, 2, 1'b0, 1'b0, t);
        wait_row(s);
        check("dir_latency", 64'(s - t), 64'd9);
        check("dir_row", 64'(row_data), 64'h00FAC688);
        repeat (20) @(negedge clk);
        check("stall_row_valid", 64'(row_valid), 64'd1);
        check("stall_row_data", 64'(row_data), 64'h00FAC688);
        check("stall_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        row_ready = 1'b1;
        wait_idle();

        // Mirrored: pixel p holds 7-p -> fields 0,1,..,7 from p7 down to p0.
        send(5, 2, 1'b1, 1'b0, t);
        wait_row(s);
        check("flip_row", 64'(row_data), 64'h00053977);
        wait_idle();

        // Flush in the 4th FETCH cycle.
        send(9, 5, 1'b0, 1'b0, t);
        repeat (3) @(posedge clk);
        #1;
        check("fetch4_ren", 64'(mem_ren), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flushed_ren", 64'(mem_ren), 64'd0);
        check("flushed_busy", 64'(busy), 64'd0);
        check("flushed_ready", 64'(req_ready), 64'd1);
        repeat (15) @(negedge clk);
        check("flushed_no_row", 64'(row_valid), 64'd0);
        @(posedge clk);
        #1;

        // Flush together with a request in IDLE must not accept it.
        req_tile  = 6'd3;
        req_row   = 3'd4;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_req_busy", 64'(busy), 64'd0);
        check("flush_req_ren", 64'(mem_ren), 64'd0);
        send(12, 7, 1'b1, 1'b0, t);
        wait_idle();

        // Reset pulse in LAST.
        send(20, 1, 1'b1, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        check("last_ren", 64'(mem_ren), 64'd0);
        check("last_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("arst_mem_ren", 64'(mem_ren), 64'd0);
        check("arst_mem_raddr", 64'(mem_raddr), 64'd0);
        check("arst_row_valid", 64'(row_valid), 64'd0);
        check("arst_row_data", 64'(row_data), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        repeat (15) @(negedge clk);
        check("arst_no_row", 64'(row_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random texture contents from here on.
        for (int a = 0; a < (1 << AW); a++) mem[a] = 3'($urandom);

        // Back-to-back requests, consumer always ready.
        row_ready = 1'b1;
        prev_t    = -1;
        for (int k = 0; k < 12; k++) begin
            send(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 1'($urandom), 1'b1, t);
            if (k > 0) check("b2b_period", 64'(t - prev_t), 64'd11);
            prev_t = t;
        end
        req_valid = 1'b0;
        wait_idle();

        // Random traffic: consumer stalls, request gaps, occasional flush.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            acc = req_valid && req_ready && !flush;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (acc) req_valid = 1'b0;
            row_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_tile  = TB_TILE_BITS'($urandom);
                req_row   = 3'($urandom);
                req_flip  = 1'($urandom);
                req_valid = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) flush = 1'b1;
        end
        flush     = 1'b0;
        req_valid = 1'b0;
        row_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        check("rows_drained", 64'(row_q.size()), 64'd0);
        check("reads_drained", 64'(addr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, expected the run to finish first");
        $fatal(1, "watchdog expired");
    end

endmodule
